dds_sweep_ctrl: RTL
===================

Name: dds_sweep_ctrl

Overview:
- Avalon-MM slave that sequences the 10-bit DDS tuning word, replacing static PIO writes with hardware-timed sweeps.
- Steps `out_port` from START to STOP by STEP, holding each point for DWELL+1 clocks.
- Supports one-shot or continuous sweeps, abort, and a manual direct-write mode.
- Sits between the HPS lightweight bridge and the DDS core's tuning-word input.

Parameters:
- WIDTH, 10, tuning word width (`out_port`, START, STOP, STEP, MANUAL).
- DWELL_W, 16, dwell counter width.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- address  input  3  register select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  combinational read mux, zero-extended
- out_port  output  WIDTH  tuning word to DDS
- busy  output  1  sweep in progress

Behaviour:
- Interface (already decided): one clock, `clk`. Reset `reset` is asynchronous and active-high. All state is registered on posedge `clk` or posedge `reset`.
- Write qualifier: chipselect && !write_n. No wait states.
- Register map:
  - 0 CTRL: bit0 START (self-clearing), bit1 ABORT (self-clearing), bit2 CONT (sticky).
  - 1 START_VAL.
  - 2 STOP_VAL.
  - 3 STEP.
  - 4 DWELL.
  - 5 STATUS: bit0 busy, bit1 done; write 1 to bit1 to clear done.
  - 6 MANUAL.
  - 7 reserved (reads 0).
- readdata: combinational function of `address` and current register contents. Reads have no side effects.
- Reset values:
  - out_port = 0x3FF; busy = 0; done = 0; CONT = 0.
  - START_VAL = 0; STOP_VAL = 0x3FF; STEP = 1; DWELL = 0.
- States: IDLE, DWELL. busy = (state == DWELL).
- IDLE:
  - A START write loads the working copies (start, stop, step, dwell) from the registers.
  - At the same edge: out_port <= START_VAL, cnt <= DWELL, done <= 0, state <= DWELL.
  - out_port shows START_VAL on the cycle after the write is sampled.
- DWELL, cnt != 0: cnt decrements.
- DWELL, cnt == 0:
  - If out_port == stop and CONT = 0: state <= IDLE, done <= 1; out_port holds stop.
  - If out_port == stop and CONT = 1: out_port <= start, cnt <= dwell.
  - Otherwise: out_port <= next value, cnt <= dwell.
- Each point is held exactly dwell+1 cycles.
- Next-value arithmetic:
  - Direction is up if start <= stop, else down.
  - Up: if (stop − out) <= step, next = stop; else next = out + step.
  - Down: mirrored.
  - Compare in WIDTH+1 bits. Never wraps past 0 or 0x3FF; always lands exactly on stop.
  - A working step of 0 is treated as 1.
- start == stop: first point is stop. One-shot ends after dwell+1 cycles. Continuous holds stop indefinitely.
- Configuration writes during a sweep update the registers (and readback) only. The active sweep uses its working copies; changes apply to the next START.
- CONT is read live, so clearing it mid-sweep ends the sweep at the next arrival at stop.
- ABORT: from any state, next edge state <= IDLE, out_port holds its current value, done unchanged.
- ABORT and START in the same write: ABORT wins and no sweep starts.
- START while busy: ignored.
- MANUAL write: when IDLE, out_port <= writedata[WIDTH-1:0] at the next edge. When busy, the write is stored for readback but out_port is unchanged.
- Reset asserted mid-sweep: all registers and outputs return to reset values immediately (asynchronously).

Optional Feature:
- Macro DDS_SWEEP_IRQ_EN.
- When defined:
  - Adds output port `irq` (1 bit) and CTRL bit3 IEN (sticky, reset 0).
  - irq = done & IEN, registered, deasserts the cycle after done is cleared.
- When undefined: no `irq` port; CTRL bit3 reads 0 and writes to it are ignored.

Decomposition:
- Package dds_sweep_pkg holds:
  - register address localparams (0–6);
  - CTRL/STATUS bit indices;
  - state enum {IDLE, DWELL};
  - reset-default constants (0x3FF, 0, 1, 0).
- One combinational sub-module, dds_sweep_next, computes the next value (out, start, stop, step → next, at_stop).

Test Plan:
- Reset, then read all registers -> out_port = 0x3FF, STATUS = 0, STOP_VAL = 0x3FF, STEP = 1.
- START = 10, STOP = 20, STEP = 3, DWELL = 2, CONT = 0, START -> out_port sequence 10, 13, 16, 19, 20, each held 3 cycles; then busy = 0, done = 1.
- START = 100, STOP = 90, STEP = 4, DWELL = 0, CONT = 1 -> 100, 96, 92, 90, 100, 96 … one cycle each. ABORT while at 92 -> holds 92, busy = 0, done = 0.
- During a sweep, write STEP = 50 and MANUAL = 0x155 -> sweep unchanged, out_port not 0x155. After done, MANUAL = 0x155 -> out_port = 0x155 on the next cycle.
- Write CTRL = START|ABORT while IDLE -> no sweep, busy stays 0. STEP = 0 with START = 0, STOP = 3 -> 0, 1, 2, 3.
- With DDS_SWEEP_IRQ_EN: IEN = 1, sweep completes -> irq = 1; write STATUS bit1 -> irq = 0 on the next cycle. Assert reset mid-sweep -> out_port = 0x3FF and irq = 0 immediately.

Source files
------------

// File: rtl/dds_sweep_pkg.sv
// Shared definitions for the DDS tuning-word sweep controller: register map,
// CTRL/STATUS bit positions, FSM states and reset defaults.
package dds_sweep_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_START  = 3'd1;
  localparam logic [2:0] ADDR_STOP   = 3'd2;
  localparam logic [2:0] ADDR_STEP   = 3'd3;
  localparam logic [2:0] ADDR_DWELL  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_MANUAL = 3'd6;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_CONT_BIT  = 2;
  localparam int CTRL_IEN_BIT   = 3;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_e;

  localparam logic [31:0] RST_OUT_PORT = 32'h0000_03FF;
  localparam logic [31:0] RST_START    = 32'h0000_0000;
  localparam logic [31:0] RST_STOP     = 32'h0000_03FF;
  localparam logic [31:0] RST_STEP     = 32'h0000_0001;
  localparam logic [31:0] RST_DWELL    = 32'h0000_0000;
  localparam logic [31:0] RST_MANUAL   = 32'h0000_0000;

endpackage

// File: rtl/dds_sweep_next.sv
// Next sweep point: moves from cur towards stop by step, clamping so the
// sweep lands exactly on stop and never wraps.
module dds_sweep_next
  import dds_sweep_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] start_i,
  input  logic [WIDTH-1:0] stop_i,
  input  logic [WIDTH-1:0] step_i,
  output logic [WIDTH-1:0] next_o,
  output logic             at_stop_o
);

  logic [WIDTH-1:0] step_eff_s;
  logic [WIDTH:0]   gap_s;

  // Direction-aware clamped step; the gap is taken one bit wider so it cannot alias.
  always_comb begin
    step_eff_s = step_i;
    gap_s      = {(WIDTH+1){1'b0}};
    next_o     = cur_i;
    if (step_i == {WIDTH{1'b0}}) begin
      step_eff_s = WIDTH'(1);
    end else begin
      step_eff_s = step_i;
    end
    if (start_i <= stop_i) begin
      gap_s = {1'b0, stop_i} - {1'b0, cur_i};
      if (gap_s <= {1'b0, step_eff_s}) begin
        next_o = stop_i;
      end else begin
        next_o = cur_i + step_eff_s;
      end
    end else begin
      gap_s = {1'b0, cur_i} - {1'b0, stop_i};
      if (gap_s <= {1'b0, step_eff_s}) begin
        next_o = stop_i;
      end else begin
        next_o = cur_i - step_eff_s;
      end
    end
  end

  assign at_stop_o = (cur_i == stop_i);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Avalon-MM sweep sequencer for the DDS tuning word.
// Optional interrupt output and CTRL.IEN bit when DDS_SWEEP_IRQ_EN is defined.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int DWELL_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
`ifdef DDS_SWEEP_IRQ_EN
  ,
  output logic             irq
`endif
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               cont_q, cont_d;
  logic [WIDTH-1:0]   start_q, start_d;
  logic [WIDTH-1:0]   stop_q, stop_d;
  logic [WIDTH-1:0]   step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [WIDTH-1:0]   manual_q, manual_d;
  logic [WIDTH-1:0]   ws_start_q, ws_start_d;
  logic [WIDTH-1:0]   ws_stop_q, ws_stop_d;
  logic [WIDTH-1:0]   ws_step_q, ws_step_d;
  logic [DWELL_W-1:0] ws_dwell_q, ws_dwell_d;
`ifdef DDS_SWEEP_IRQ_EN
  logic               ien_q, ien_d;
  logic               irq_q;
`endif

  logic             wr_s;
  logic             start_cmd_s;
  logic             abort_cmd_s;
  logic             manual_wr_s;
  logic [WIDTH-1:0] next_s;
  logic             at_stop_s;
  logic             unused_wdata_s;

  assign wr_s           = chipselect && !write_n;
  assign start_cmd_s    = wr_s && (address == ADDR_CTRL) && writedata[CTRL_START_BIT]
                          && !writedata[CTRL_ABORT_BIT];
  assign abort_cmd_s    = wr_s && (address == ADDR_CTRL) && writedata[CTRL_ABORT_BIT];
  assign manual_wr_s    = wr_s && (address == ADDR_MANUAL);
  assign unused_wdata_s = ^writedata[31:DWELL_W];

  dds_sweep_next #(.WIDTH(WIDTH)) u_next (
    .cur_i     (out_q),
    .start_i   (ws_start_q),
    .stop_i    (ws_stop_q),
    .step_i    (ws_step_q),
    .next_o    (next_s),
    .at_stop_o (at_stop_s)
  );

  // Register-file updates and sweep FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    cont_d     = cont_q;
    start_d    = start_q;
    stop_d     = stop_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    manual_d   = manual_q;
    ws_start_d = ws_start_q;
    ws_stop_d  = ws_stop_q;
    ws_step_d  = ws_step_q;
    ws_dwell_d = ws_dwell_q;
`ifdef DDS_SWEEP_IRQ_EN
    ien_d      = ien_q;
`endif

    if (wr_s) begin
      case (address)
        ADDR_CTRL: begin
          cont_d = writedata[CTRL_CONT_BIT];
`ifdef DDS_SWEEP_IRQ_EN
          ien_d  = writedata[CTRL_IEN_BIT];
`endif
        end
        ADDR_START:  start_d  = writedata[WIDTH-1:0];
        ADDR_STOP:   stop_d   = writedata[WIDTH-1:0];
        ADDR_STEP:   step_d   = writedata[WIDTH-1:0];
        ADDR_DWELL:  dwell_d  = writedata[DWELL_W-1:0];
        ADDR_STATUS: begin
          if (writedata[STAT_DONE_BIT]) begin
            done_d = 1'b0;
          end else begin
            done_d = done_q;
          end
        end
        ADDR_MANUAL: manual_d = writedata[WIDTH-1:0];
        default:     done_d   = done_q;
      endcase
    end else begin
      done_d = done_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_cmd_s) begin
          ws_start_d = start_q;
          ws_stop_d  = stop_q;
          ws_step_d  = step_q;
          ws_dwell_d = dwell_q;
          out_d      = start_q;
          cnt_d      = dwell_q;
          done_d     = 1'b0;
          state_d    = ST_DWELL;
        end else if (manual_wr_s) begin
          out_d = writedata[WIDTH-1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DWELL: begin
        // Abort leaves out_port frozen on whatever point was being held.
        if (abort_cmd_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q != {DWELL_W{1'b0}}) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (at_stop_s) begin
          if (cont_q) begin
            out_d = ws_start_q;
            cnt_d = ws_dwell_q;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          out_d = next_s;
          cnt_d = ws_dwell_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      out_q      <= WIDTH'(RST_OUT_PORT);
      cnt_q      <= {DWELL_W{1'b0}};
      done_q     <= 1'b0;
      cont_q     <= 1'b0;
      start_q    <= WIDTH'(RST_START);
      stop_q     <= WIDTH'(RST_STOP);
      step_q     <= WIDTH'(RST_STEP);
      dwell_q    <= DWELL_W'(RST_DWELL);
      manual_q   <= WIDTH'(RST_MANUAL);
      ws_start_q <= WIDTH'(RST_START);
      ws_stop_q  <= WIDTH'(RST_STOP);
      ws_step_q  <= WIDTH'(RST_STEP);
      ws_dwell_q <= DWELL_W'(RST_DWELL);
`ifdef DDS_SWEEP_IRQ_EN
      ien_q      <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      cont_q     <= cont_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      manual_q   <= manual_d;
      ws_start_q <= ws_start_d;
      ws_stop_q  <= ws_stop_d;
      ws_step_q  <= ws_step_d;
      ws_dwell_q <= ws_dwell_d;
`ifdef DDS_SWEEP_IRQ_EN
      ien_q      <= ien_d;
      irq_q      <= done_q & ien_q;
`endif
    end
  end

  assign out_port = out_q;
  assign busy     = (state_q == ST_DWELL);
`ifdef DDS_SWEEP_IRQ_EN
  assign irq      = irq_q;
`endif

  // Side-effect-free read mux, zero-extended to the bus width.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_CONT_BIT] = cont_q;
`ifdef DDS_SWEEP_IRQ_EN
        readdata[CTRL_IEN_BIT]  = ien_q;
`endif
      end
      ADDR_START:  readdata[WIDTH-1:0]   = start_q;
      ADDR_STOP:   readdata[WIDTH-1:0]   = stop_q;
      ADDR_STEP:   readdata[WIDTH-1:0]   = step_q;
      ADDR_DWELL:  readdata[DWELL_W-1:0] = dwell_q;
      ADDR_STATUS: begin
        readdata[STAT_BUSY_BIT] = busy;
        readdata[STAT_DONE_BIT] = done_q;
      end
      ADDR_MANUAL: readdata[WIDTH-1:0]   = manual_q;
      default:     readdata              = 32'd0;
    endcase
  end

endmodule
